// File: rtl/mem_access.sv
// Memory-access stage: issues RV32 loads/stores on a req/ack bus, aligns/extends load data, stalls while pending.
// Optional watchdog on unacknowledged requests is enabled with `define MEM_TIMEOUT_EN.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef INSTR_W
`define INSTR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef REG_IDX_W
`define REG_IDX_W 5
`endif
`ifndef DEST_SRC_W
`define DEST_SRC_W 2
`endif
`ifndef DEST_SRC_NONE
`define DEST_SRC_NONE 2'd0
`endif

module mem_access #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   stall,
    input  logic [`ADDR_W-1:0]     i_pc,
    input  logic [`INSTR_W-1:0]    i_instr,
    input  logic [`DEST_SRC_W-1:0] i_dest_src,
    input  logic [`REG_IDX_W-1:0]  i_dest_reg,
    input  logic [`WORD_W-1:0]     i_alu_eval,
    input  logic [`WORD_W-1:0]     i_store_data,
    output logic [`ADDR_W-1:0]     o_pc,
    output logic [`INSTR_W-1:0]    o_instr,
    output logic [`DEST_SRC_W-1:0] o_dest_src,
    output logic [`REG_IDX_W-1:0]  o_dest_reg,
    output logic [`WORD_W-1:0]     o_wb_data,
    output logic                   o_stall_req,
    output logic                   o_misalign,
    output logic                   o_mem_req,
    output logic                   o_mem_we,
    output logic [`ADDR_W-1:0]     o_mem_addr,
    output logic [3:0]             o_mem_be,
    output logic [`WORD_W-1:0]     o_mem_wdata,
    input  logic                   i_mem_ack,
    input  logic [`WORD_W-1:0]     i_mem_rdata
`ifdef MEM_TIMEOUT_EN
    ,
    output logic                   o_mem_fault
`endif
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = a[0];
            default: misaligned = (a != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   byte_en = 4'b0001 << a;
            2'b01:   byte_en = a[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [`WORD_W-1:0] store_lanes(input logic [2:0] f3, input logic [`WORD_W-1:0] d);
        case (f3[1:0])
            2'b00:   store_lanes = {4{d[7:0]}};
            2'b01:   store_lanes = {2{d[15:0]}};
            default: store_lanes = d;
        endcase
    endfunction

    // funct3[2] marks the unsigned variants (LBU/LHU)
    function automatic logic [`WORD_W-1:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                       input logic [`WORD_W-1:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{a, 3'b000} +: 8];
        h = a[1] ? rd[31:16] : rd[15:0];
        case (f3[1:0])
            2'b00:   load_extend = {{24{~f3[2] & b[7]}}, b};
            2'b01:   load_extend = {{16{~f3[2] & h[15]}}, h};
            default: load_extend = rd;
        endcase
    endfunction

    state_t                  r_state;
    logic [`ADDR_W-1:0]      r_pc;
    logic [`INSTR_W-1:0]     r_instr;
    logic [`DEST_SRC_W-1:0]  r_dest_src;
    logic [`REG_IDX_W-1:0]   r_dest_reg;
    logic [`WORD_W-1:0]      r_alu;
    logic [`WORD_W-1:0]      r_store;
    logic [`WORD_W-1:0]      r_load_data;

    logic [2:0] w_f3;
    logic       w_is_load;
    logic       w_is_store;
    logic       w_misalign;
    logic       w_in_go;
    logic       w_ack;
    logic       w_fault;
    logic [`WORD_W-1:0] w_wb;

    assign w_f3       = r_instr[14:12];
    assign w_is_load  = (r_instr[6:0] == OP_LOAD);
    assign w_is_store = (r_instr[6:0] == OP_STORE);
    assign w_misalign = (w_is_load | w_is_store) & misaligned(w_f3, r_alu[1:0]);
    assign w_in_go    = ((i_instr[6:0] == OP_LOAD) | (i_instr[6:0] == OP_STORE)) &
                        ~misaligned(i_instr[14:12], i_alu_eval[1:0]);
    assign w_ack      = (r_state == S_REQ) & i_mem_ack;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             r_fault;
    assign w_fault     = r_fault;
    assign o_mem_fault = r_fault;
`else
    assign w_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_instr     <= '0;
            r_dest_src  <= `DEST_SRC_NONE;
            r_dest_reg  <= '0;
            r_alu       <= '0;
            r_store     <= '0;
            r_load_data <= '0;
`ifdef MEM_TIMEOUT_EN
            r_cnt       <= '0;
            r_fault     <= 1'b0;
`endif
        end else if (!stall) begin
            r_pc       <= i_pc;
            r_instr    <= i_instr;
            r_dest_src <= i_dest_src;
            r_dest_reg <= i_dest_reg;
            r_alu      <= i_alu_eval;
            r_store    <= i_store_data;
            r_state    <= w_in_go ? S_REQ : S_IDLE;
`ifdef MEM_TIMEOUT_EN
            r_cnt      <= '0;
            r_fault    <= 1'b0;
`endif
        end else if (r_state == S_REQ) begin
            // ack under an external stall: keep the data so it survives until capture
            if (i_mem_ack) begin
                r_load_data <= load_extend(w_f3, r_alu[1:0], i_mem_rdata);
                r_state     <= S_DONE;
            end
`ifdef MEM_TIMEOUT_EN
            else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                r_state <= S_DONE;
                r_fault <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
`endif
        end
    end

    always_comb begin
        w_wb = r_alu;
        if (w_ack && w_is_load)
            w_wb = load_extend(w_f3, r_alu[1:0], i_mem_rdata);
        else if ((r_state == S_DONE) && w_is_load)
            w_wb = r_load_data;
        if (w_fault)
            w_wb = '0;
    end

    assign o_pc        = r_pc;
    assign o_instr     = r_instr;
    assign o_dest_reg  = r_dest_reg;
    assign o_dest_src  = (w_misalign | w_fault) ? `DEST_SRC_NONE : r_dest_src;
    assign o_wb_data   = w_wb;
    assign o_misalign  = w_misalign;
    assign o_mem_req   = (r_state == S_REQ);
    assign o_stall_req = (r_state == S_REQ) & ~i_mem_ack;
    assign o_mem_we    = w_is_store;
    assign o_mem_addr  = {r_alu[`ADDR_W-1:2], 2'b00};
    assign o_mem_be    = byte_en(w_f3, r_alu[1:0]);
    assign o_mem_wdata = store_lanes(w_f3, r_store);

endmodule
